fifo_sync: RTL and testbench

- Parametrised synchronous ready/valid FIFO; successor to the fixed-width fifo.
- Adds configurable data width, any depth ≥2 (power of two not required), first-word-fall-through read port, occupancy count, almost-full/almost-empty flags and synchronous flush.
- Sits between streaming producers and consumers in the same clock domain; used as an elastic buffer and for rate decoupling.

---
 rtl/fifo_sync_pkg.sv | 25 ++
 rtl/fifo_sync_if.sv | 39 +++
 rtl/fifo_sync_ptr.sv | 48 ++++
 rtl/fifo_sync.sv | 96 +++++++++
 tb/tb_fifo_sync.sv | 197 +++++++++++++++++++
 5 files changed

// File: rtl/fifo_sync_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fifo_pkg
// Description : Shared sizing helpers and default parameters for fifo_sync.
// Revision    : 1.0 - initial release
// ============================================================================
package fifo_pkg;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_FIFO_DEPTH = 4;

  // Occupancy counter must represent 0..depth inclusive.
  function automatic int cnt_width(input int depth);
    return $clog2(depth + 1);
  endfunction

  // Pointer addresses 0..depth-1; never narrower than one bit.
  function automatic int ptr_width(input int depth);
    int w;
    w = $clog2(depth);
    return (w < 1) ? 1 : w;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fifo_sync_if.sv
`default_nettype none
// ============================================================================
// Module      : fifo_sync_if
// Description : Write/read handshake, flush and status bundle for fifo_sync.
//               master = producer/consumer side, slave = FIFO side.
// Revision    : 1.0 - initial release
// ============================================================================
interface fifo_sync_if #(
  parameter int DATA_WIDTH = fifo_pkg::DEF_DATA_WIDTH,
  parameter int FIFO_DEPTH = fifo_pkg::DEF_FIFO_DEPTH
) ();

  localparam int CNT_W = fifo_pkg::cnt_width(FIFO_DEPTH);

  logic                  i_flush;
  logic                  i_write_valid;
  logic                  o_write_ready;
  logic [DATA_WIDTH-1:0] i_write_data;
  logic                  o_read_valid;
  logic                  i_read_ready;
  logic [DATA_WIDTH-1:0] o_read_data;
  logic [CNT_W-1:0]      o_count;
  logic                  o_almost_full;
  logic                  o_almost_empty;

  modport master (
    output i_flush, i_write_valid, i_write_data, i_read_ready,
    input  o_write_ready, o_read_valid, o_read_data, o_count,
           o_almost_full, o_almost_empty
  );

  modport slave (
    input  i_flush, i_write_valid, i_write_data, i_read_ready,
    output o_write_ready, o_read_valid, o_read_data, o_count,
           o_almost_full, o_almost_empty
  );

endinterface
`default_nettype wire

// File: rtl/fifo_sync_ptr.sv
`default_nettype none
// ============================================================================
// Module      : fifo_ptr
// Description : Wrapping pointer 0..DEPTH-1 with synchronous clear.
//               Wrap is an explicit compare so any DEPTH works.
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_ptr
  import fifo_pkg::*;
#(
  parameter int DEPTH = DEF_FIFO_DEPTH
) (
  input  wire logic                         i_clock,
  input  wire logic                         i_nreset,
  input  wire logic                         i_clear,
  input  wire logic                         i_inc,
  output logic [ptr_width(DEPTH)-1:0]       o_ptr
);

  localparam int PW = ptr_width(DEPTH);
  localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

  logic [PW-1:0] ptr_d;
  logic [PW-1:0] ptr_q;

  // Next pointer: clear wins over increment; wrap at the last slot.
  always_comb begin
    ptr_d = ptr_q;
    if (i_clear) begin
      ptr_d = '0;
    end else if (i_inc) begin
      ptr_d = (ptr_q == LAST) ? '0 : ptr_q + 1'b1;
    end
  end

  // Pointer register with synchronous active-low reset.
  always_ff @(posedge i_clock) begin
    if (!i_nreset) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign o_ptr = ptr_q;

endmodule
`default_nettype wire

// File: rtl/fifo_sync.sv
`default_nettype none
// ============================================================================
// Module      : fifo_sync
// Description : Parametrised synchronous ready/valid FIFO with first-word-
//               fall-through read, occupancy count, almost flags and flush.
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_sync
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
  parameter int FIFO_DEPTH   = DEF_FIFO_DEPTH,
  parameter int AFULL_LEVEL  = FIFO_DEPTH - 1,
  parameter int AEMPTY_LEVEL = 1
) (
  input  wire logic   i_clock,
  input  wire logic   i_nreset,
  fifo_sync_if.slave  bus
);

  localparam int CNT_W = cnt_width(FIFO_DEPTH);
  localparam int PW    = ptr_width(FIFO_DEPTH);

  logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [CNT_W-1:0]      count_d;
  logic [CNT_W-1:0]      count_q;
  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;
  logic                  wr_en;
  logic                  rd_en;

  // Ready never looks at i_read_ready: a full FIFO refuses writes even when
  // the head is being popped in the same cycle.
  assign bus.o_write_ready  = (int'(count_q) < FIFO_DEPTH) && !bus.i_flush;
  assign bus.o_read_valid   = (count_q != '0);
  assign bus.o_read_data    = mem_q[rd_ptr];
  assign bus.o_count        = count_q;
  assign bus.o_almost_full  = (int'(count_q) >= AFULL_LEVEL);
  assign bus.o_almost_empty = (int'(count_q) <= AEMPTY_LEVEL);

  assign wr_en = bus.i_write_valid && bus.o_write_ready;
  assign rd_en = bus.o_read_valid && bus.i_read_ready;

  fifo_ptr #(.DEPTH(FIFO_DEPTH)) u_wr_ptr (
    .i_clock  (i_clock),
    .i_nreset (i_nreset),
    .i_clear  (bus.i_flush),
    .i_inc    (wr_en),
    .o_ptr    (wr_ptr)
  );

  fifo_ptr #(.DEPTH(FIFO_DEPTH)) u_rd_ptr (
    .i_clock  (i_clock),
    .i_nreset (i_nreset),
    .i_clear  (bus.i_flush),
    .i_inc    (rd_en),
    .o_ptr    (rd_ptr)
  );

  // Occupancy: flush empties; simultaneous read and write cancel out.
  always_comb begin
    count_d = count_q;
    if (bus.i_flush) begin
      count_d = '0;
    end else if (wr_en && !rd_en) begin
      count_d = count_q + 1'b1;
    end else if (rd_en && !wr_en) begin
      count_d = count_q - 1'b1;
    end
  end

  // Occupancy register with synchronous active-low reset.
  always_ff @(posedge i_clock) begin
    if (!i_nreset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // Storage is not reset; only accepted writes touch it.
  always_ff @(posedge i_clock) begin
    if (i_nreset && wr_en) begin
      mem_q[wr_ptr] <= bus.i_write_data;
    end
  end

  a_count_bound : assert property (@(posedge i_clock) disable iff (!i_nreset)
    int'(count_q) <= FIFO_DEPTH);
  a_valid_nonempty : assert property (@(posedge i_clock) disable iff (!i_nreset)
    !(bus.o_read_valid && count_q == '0));
  a_no_write_full : assert property (@(posedge i_clock) disable iff (!i_nreset)
    !(wr_en && int'(count_q) == FIFO_DEPTH));

endmodule
`default_nettype wire

// File: tb/tb_fifo_sync.sv
`default_nettype none
// ============================================================================
// Module      : tb_fifo_sync
// Description : Scoreboard bench for fifo_sync, DEPTH=5, WIDTH=8.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fifo_sync;

  localparam int DEPTH = 5;
  localparam int WIDTH = 8;

  logic clk;
  logic nreset;
  logic [7:0] exp_q[$];
  int n_cmp;
  int n_fail;

  fifo_sync_if #(.DATA_WIDTH(WIDTH), .FIFO_DEPTH(DEPTH)) bus ();

  fifo_sync #(.DATA_WIDTH(WIDTH), .FIFO_DEPTH(DEPTH)) dut (
    .i_clock  (clk),
    .i_nreset (nreset),
    .bus      (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one cycle of stimulus, advance the reference queue at the edge,
  // then return inputs to idle 1 ns after the edge.
  task automatic step(input logic wv, input logic [7:0] wd, input logic rr,
                      input logic fl, input logic rn);
    int  n;
    bit  acc_w;
    bit  acc_r;
    bus.i_write_valid = wv;
    bus.i_write_data  = wd;
    bus.i_read_ready  = rr;
    bus.i_flush       = fl;
    nreset            = rn;
    @(posedge clk);
    n     = exp_q.size();
    acc_w = wv && !fl && (n < DEPTH);
    acc_r = rr && (n > 0);
    if (!rn || fl) begin
      exp_q.delete();
    end else begin
      if (acc_r) void'(exp_q.pop_front());
      if (acc_w) exp_q.push_back(wd);
    end
    #1;
    bus.i_write_valid = 1'b0;
    bus.i_read_ready  = 1'b0;
    bus.i_flush       = 1'b0;
    nreset            = 1'b1;
  endtask

  task automatic test_reset();
    step(0, 8'h00, 0, 0, 0);
    step(0, 8'h00, 0, 0, 0);
    n_cmp++; if (bus.o_read_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", bus.o_read_valid); end
    n_cmp++; if (bus.o_write_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready got %b want 1", bus.o_write_ready); end
    n_cmp++; if (bus.o_count !== 3'd0) begin n_fail++; $display("FAIL reset_count got %0d want 0", bus.o_count); end
    n_cmp++; if (bus.o_almost_empty !== 1'b1) begin n_fail++; $display("FAIL reset_aempty got %b want 1", bus.o_almost_empty); end
    n_cmp++; if (bus.o_almost_full !== 1'b0) begin n_fail++; $display("FAIL reset_afull got %b want 0", bus.o_almost_full); end
  endtask

  task automatic test_single();
    bus.i_write_valid = 1'b1;
    bus.i_write_data  = 8'd12;
    #1;
    n_cmp++; if (bus.o_read_valid !== 1'b0) begin n_fail++; $display("FAIL single_nobypass got %b want 0", bus.o_read_valid); end
    step(1, 8'd12, 0, 0, 1);
    n_cmp++; if (bus.o_read_valid !== 1'b1) begin n_fail++; $display("FAIL single_valid got %b want 1", bus.o_read_valid); end
    n_cmp++; if (bus.o_read_data !== 8'd12) begin n_fail++; $display("FAIL single_data got %0d want 12", bus.o_read_data); end
    n_cmp++; if (bus.o_count !== 3'd1) begin n_fail++; $display("FAIL single_count got %0d want 1", bus.o_count); end
    n_cmp++; if (bus.o_almost_empty !== 1'b1) begin n_fail++; $display("FAIL single_aempty got %b want 1", bus.o_almost_empty); end
    n_cmp++; if (bus.o_read_data !== exp_q[0]) begin n_fail++; $display("FAIL single_sb got %0d want %0d", bus.o_read_data, exp_q[0]); end
    step(0, 8'h00, 1, 0, 1);
    n_cmp++; if (bus.o_read_valid !== 1'b0) begin n_fail++; $display("FAIL single_drained got %b want 0", bus.o_read_valid); end
  endtask

  task automatic test_fill_full();
    for (int i = 1; i <= 5; i++) begin
      step(1, 8'(i), 0, 0, 1);
      if (i == 2) begin
        n_cmp++; if (bus.o_almost_empty !== 1'b0) begin n_fail++; $display("FAIL fill_aempty2 got %b want 0", bus.o_almost_empty); end
      end
      if (i == 4) begin
        n_cmp++; if (bus.o_almost_full !== 1'b1) begin n_fail++; $display("FAIL fill_afull4 got %b want 1", bus.o_almost_full); end
      end
    end
    n_cmp++; if (bus.o_write_ready !== 1'b0) begin n_fail++; $display("FAIL full_ready got %b want 0", bus.o_write_ready); end
    n_cmp++; if (bus.o_count !== 3'd5) begin n_fail++; $display("FAIL full_count got %0d want 5", bus.o_count); end
    n_cmp++; if (bus.o_almost_full !== 1'b1) begin n_fail++; $display("FAIL full_afull got %b want 1", bus.o_almost_full); end
    step(1, 8'd99, 0, 0, 1);
    n_cmp++; if (bus.o_count !== 3'd5) begin n_fail++; $display("FAIL full_overwrite_count got %0d want 5", bus.o_count); end
    // Full: simultaneous read and write pops the head and refuses the write.
    n_cmp++; if (bus.o_read_data !== 8'd1) begin n_fail++; $display("FAIL fullrw_head got %0d want 1", bus.o_read_data); end
    step(1, 8'd6, 1, 0, 1);
    n_cmp++; if (bus.o_count !== 3'd4) begin n_fail++; $display("FAIL fullrw_count got %0d want 4", bus.o_count); end
    step(1, 8'd6, 0, 0, 1);
    n_cmp++; if (bus.o_count !== 3'd5) begin n_fail++; $display("FAIL refill_count got %0d want 5", bus.o_count); end
    for (int k = 2; k <= 6; k++) begin
      n_cmp++;
      if (exp_q.size() == 0 || bus.o_read_data !== exp_q[0] || bus.o_read_data !== 8'(k)) begin
        n_fail++; $display("FAIL fullrw_order got %0d want %0d", bus.o_read_data, k);
      end
      step(0, 8'h00, 1, 0, 1);
    end
    n_cmp++; if (bus.o_read_valid !== 1'b0) begin n_fail++; $display("FAIL fullrw_empty got %b want 0", bus.o_read_valid); end
  endtask

  task automatic test_stream();
    int out_k;
    out_k = 0;
    step(1, 8'd0, 0, 0, 1);
    step(1, 8'd1, 0, 0, 1);
    for (int k = 2; k <= 19; k++) begin
      n_cmp++; if (bus.o_count !== 3'd2) begin n_fail++; $display("FAIL stream_count got %0d want 2", bus.o_count); end
      n_cmp++;
      if (exp_q.size() == 0 || bus.o_read_data !== exp_q[0] || bus.o_read_data !== 8'(out_k)) begin
        n_fail++; $display("FAIL stream_data got %0d want %0d", bus.o_read_data, out_k);
      end
      step(1, 8'(k), 1, 0, 1);
      out_k++;
    end
    while (out_k < 20) begin
      n_cmp++;
      if (bus.o_read_valid !== 1'b1 || bus.o_read_data !== 8'(out_k)) begin
        n_fail++; $display("FAIL stream_tail got v=%b d=%0d want v=1 d=%0d", bus.o_read_valid, bus.o_read_data, out_k);
      end
      step(0, 8'h00, 1, 0, 1);
      out_k++;
    end
    n_cmp++; if (bus.o_count !== 3'd0) begin n_fail++; $display("FAIL stream_end_count got %0d want 0", bus.o_count); end
  endtask

  task automatic test_flush();
    for (int i = 0; i < 3; i++) step(1, 8'(30 + i), 0, 0, 1);
    bus.i_flush       = 1'b1;
    bus.i_write_valid = 1'b1;
    #1;
    n_cmp++; if (bus.o_write_ready !== 1'b0) begin n_fail++; $display("FAIL flush_ready got %b want 0", bus.o_write_ready); end
    step(1, 8'd77, 0, 1, 1);
    n_cmp++; if (bus.o_count !== 3'd0) begin n_fail++; $display("FAIL flush_count got %0d want 0", bus.o_count); end
    n_cmp++; if (bus.o_read_valid !== 1'b0) begin n_fail++; $display("FAIL flush_valid got %b want 0", bus.o_read_valid); end
    step(1, 8'h40, 0, 0, 1);
    n_cmp++; if (bus.o_count !== 3'd1) begin n_fail++; $display("FAIL postflush_count got %0d want 1", bus.o_count); end
    n_cmp++;
    if (exp_q.size() != 1 || bus.o_read_data !== exp_q[0] || bus.o_read_data !== 8'h40) begin
      n_fail++; $display("FAIL postflush_data got %h want 40", bus.o_read_data);
    end
    step(0, 8'h00, 1, 0, 1);
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 4; i++) step(1, 8'(50 + i), 0, 0, 1);
    step(1, 8'hEE, 1, 0, 0);
    n_cmp++; if (bus.o_count !== 3'd0) begin n_fail++; $display("FAIL midrst_count got %0d want 0", bus.o_count); end
    n_cmp++; if (bus.o_read_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_valid got %b want 0", bus.o_read_valid); end
    n_cmp++; if (bus.o_write_ready !== 1'b1) begin n_fail++; $display("FAIL midrst_ready got %b want 1", bus.o_write_ready); end
    step(1, 8'hA5, 0, 0, 1);
    n_cmp++;
    if (exp_q.size() != 1 || bus.o_read_data !== exp_q[0] || bus.o_read_data !== 8'hA5) begin
      n_fail++; $display("FAIL midrst_data got %h want a5", bus.o_read_data);
    end
    step(0, 8'h00, 1, 0, 1);
    n_cmp++; if (bus.o_read_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_drain got %b want 0", bus.o_read_valid); end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    n_cmp  = 0;
    n_fail = 0;
    nreset = 1'b0;
    bus.i_flush       = 1'b0;
    bus.i_write_valid = 1'b0;
    bus.i_write_data  = 8'h00;
    bus.i_read_ready  = 1'b0;
    test_reset();
    test_single();
    test_fill_full();
    test_stream();
    test_flush();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
